// File: rtl/pfloat_fpu_seq.sv
// pfloat_fpu_seq: multi-cycle floating-point unit for the pinkyfloat datapath.
// ADDF / SUBF / MULF / ITOF / FTOI on a sign/exponent/mantissa word with an
// implied leading one. Truncating arithmetic, saturating on overflow, fixed
// latency per op, start/busy/done handshake.
module pfloat_fpu_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 7,
    parameter int BIAS   = 127
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              op,
    input  logic [EXP_W+MANT_W:0]   op1,
    input  logic [EXP_W+MANT_W:0]   op2,
    output logic                    busy,
    output logic                    done,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    err
);

    localparam int W  = 1 + EXP_W + MANT_W;     // word and integer width
    localparam int M1 = MANT_W + 1;             // mantissa with hidden one
    localparam int PW = 2 * M1;                 // raw product width
    localparam int IW = W + 1;                  // ITOF magnitude width
    localparam int AW = (IW > PW) ? IW : PW;    // working accumulator width
    localparam int EW = EXP_W + 4;              // signed working exponent width
    localparam int FW = M1 + W;                 // FTOI shift workspace width

    localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
    localparam logic signed [EW-1:0] MANT_S   = EW'(MANT_W);
    localparam logic signed [EW-1:0] MUL_OFF  = EW'(BIAS + 2 * MANT_W);
    localparam logic signed [EW-1:0] E_MAX_S  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S    = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S   = EW'(0);
    localparam logic signed [EW-1:0] INT_LIM  = EW'(W - 1);

    localparam logic [2:0] OP_ADDF = 3'd0;
    localparam logic [2:0] OP_SUBF = 3'd1;
    localparam logic [2:0] OP_MULF = 3'd2;
    localparam logic [2:0] OP_ITOF = 3'd3;
    localparam logic [2:0] OP_FTOI = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_MUL, S_LZC, S_SHIFT, S_NORM, S_PACK
    } state_t;

    state_t state, state_n;
    logic   accept;

    // Latched operands and working registers.
    logic [W-1:0]           a_q, b_q;
    logic [AW-1:0]          acc_q;      // value = acc_q * 2^(ew_q - BIAS)
    logic [MANT_W+1:0]      small_q;    // aligned smaller addend
    logic                   sign_q, sub_q;
    logic signed [EW-1:0]   ew_q;       // biased exponent of acc_q bit 0
    logic [W-1:0]           result_q;
    logic                   err_q;

    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MANT_W-1:0]  ma, mb;
    assign {sa, ea, ma} = a_q;
    assign {sb, eb, mb} = b_q;

    // Shortcut detection on the raw inputs: zero operand or illegal op.
    logic [W-1:0] op2_eff, sc_result;
    logic         sc_hit, sc_err, in_a_zero, in_b_zero;

    // Decide at accept time whether the op completes in one cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave one unassigned and infer a latch.
        sc_hit    = 1'b0;
        sc_err    = 1'b0;
        sc_result = '0;
        op2_eff   = (op == OP_SUBF) ? {~op2[W-1], op2[W-2:0]} : op2;
        in_a_zero = (op1[W-2 -: EXP_W] == '0);
        in_b_zero = (op2[W-2 -: EXP_W] == '0);
        case (op)
            OP_ADDF, OP_SUBF: begin
                if (in_a_zero) begin
                    sc_hit    = 1'b1;
                    sc_result = in_b_zero ? '0 : op2_eff;
                end else if (in_b_zero) begin
                    sc_hit    = 1'b1;
                    sc_result = op1;
                end
            end
            OP_MULF: sc_hit = in_a_zero | in_b_zero;
            OP_ITOF: sc_hit = (op2 == '0);
            OP_FTOI: sc_hit = in_b_zero;
            default: begin
                sc_hit = 1'b1;
                sc_err = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state, handshake outputs and start acceptance.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE:               accept = start;
            S_ALIGN:              begin busy = 1'b1; state_n = S_ADD;  end
            S_ADD, S_MUL, S_LZC:  begin busy = 1'b1; state_n = S_NORM; end
            S_SHIFT, S_NORM:      begin busy = 1'b1; state_n = S_PACK; end
            S_PACK: begin
                done    = 1'b1;
                state_n = S_IDLE;
                accept  = start;
            end
            default:              state_n = S_IDLE;
        endcase
        if (accept) begin
            if (sc_hit) begin
                state_n = S_PACK;
            end else begin
                case (op)
                    OP_ADDF, OP_SUBF: state_n = S_ALIGN;
                    OP_MULF:          state_n = S_MUL;
                    OP_ITOF:          state_n = S_LZC;
                    default:          state_n = S_SHIFT;
                endcase
            end
        end
    end

    // Per-stage arithmetic from the registered working values.
    logic                   a_big;
    logic [EXP_W-1:0]       e_big, e_diff;
    logic [MANT_W:0]        m_big, m_small;
    logic [MANT_W+1:0]      al_small, add_sum;
    logic [PW-1:0]          prod;
    logic [IW-1:0]          itof_mag;
    int                     msb;
    logic signed [EW-1:0]   norm_e, ftoi_e;
    logic [W-1:0]           norm_res, ftoi_res;
    logic                   norm_err, ftoi_err;

    // Alignment, add, multiply, ITOF magnitude, normalise and FTOI conversion.
    always_comb begin
        a_big    = (a_q[W-2:0] >= b_q[W-2:0]);
        e_big    = a_big ? ea : eb;
        e_diff   = a_big ? ea - eb : eb - ea;
        m_big    = {1'b1, a_big ? ma : mb};
        m_small  = {1'b1, a_big ? mb : ma};
        al_small = (int'(e_diff) >= MANT_W + 2) ? '0 : ({1'b0, m_small} >> e_diff);
        add_sum  = sub_q ? acc_q[MANT_W+1:0] - small_q : acc_q[MANT_W+1:0] + small_q;
        prod     = PW'({1'b1, ma}) * PW'({1'b1, mb});
        itof_mag = b_q[W-1] ? (~{1'b1, b_q} + IW'(1)) : {1'b0, b_q};

        // Leading-one position drives the normalising shift and exponent.
        msb = 0;
        for (int i = 0; i < AW; i++) begin
            if (acc_q[i]) msb = i;
        end
        norm_e   = ew_q + EW'(msb);
        norm_res = '0;
        norm_err = 1'b0;
        if (acc_q != '0) begin
            if (norm_e > E_MAX_S) begin
                norm_res = {sign_q, {(W-1){1'b1}}};
                norm_err = 1'b1;
            end else if (norm_e >= ONE_S) begin
                norm_res = {sign_q, norm_e[EXP_W-1:0],
                            MANT_W'((acc_q << (AW - 1 - msb)) >> (AW - 1 - MANT_W))};
            end
        end

        // FTOI: truncate toward zero, saturate at the signed integer range.
        ftoi_e   = $signed(EW'(eb)) - BIAS_S;
        ftoi_res = '0;
        ftoi_err = 1'b0;
        if (ftoi_e >= INT_LIM) begin
            ftoi_res = sb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            ftoi_err = 1'b1;
        end else if (ftoi_e >= ZERO_S) begin
            ftoi_res = W'((FW'({1'b1, mb}) << ftoi_e) >> MANT_W);
            if (sb) ftoi_res = ~ftoi_res + W'(1);
        end
    end

    // Datapath registers: operand capture on accept, one stage per state.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the whole datapath is reset, not just the control state, so an
        // aborted op leaves result/err at zero and no stale working value survives.
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            small_q  <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            ew_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // stage reads the values from before this edge.
            if (accept) begin
                a_q <= op1;
                b_q <= op2_eff;
                if (sc_hit) begin
                    result_q <= sc_result;
                    err_q    <= sc_err;
                end
            end
            case (state)
                S_ALIGN: begin
                    acc_q   <= AW'(m_big);
                    small_q <= al_small;
                    sign_q  <= a_big ? sa : sb;
                    sub_q   <= sa ^ sb;
                    ew_q    <= $signed(EW'(e_big)) - MANT_S;
                end
                S_ADD:   acc_q <= AW'(add_sum);
                S_MUL: begin
                    acc_q  <= AW'(prod);
                    sign_q <= sa ^ sb;
                    ew_q   <= $signed(EW'(ea)) + $signed(EW'(eb)) - MUL_OFF;
                end
                S_LZC: begin
                    acc_q  <= AW'(itof_mag);
                    sign_q <= b_q[W-1];
                    ew_q   <= BIAS_S;
                end
                S_NORM: begin
                    result_q <= norm_res;
                    err_q    <= norm_err;
                end
                S_SHIFT: begin
                    result_q <= ftoi_res;
                    err_q    <= ftoi_err;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_pfloat_fpu_seq.sv
// tb_pfloat_fpu_seq: directed-vector bench for pfloat_fpu_seq (default 16-bit
// format). Each feature task drives its vectors and compares inline.
module tb_pfloat_fpu_seq;

    localparam logic [2:0] ADDF = 3'd0;
    localparam logic [2:0] SUBF = 3'd1;
    localparam logic [2:0] MULF = 3'd2;
    localparam logic [2:0] ITOF = 3'd3;
    localparam logic [2:0] FTOI = 3'd4;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [15:0] op1, op2, result;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    pfloat_fpu_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    // Present one op for a single accepting edge, then wait for done.
    // lat = cycle of done (cycle 1 follows the accepting edge), 99 on timeout.
    task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [31:0] bm);
        @(negedge clk);
        start = 1'b1; op = o; op1 = a; op2 = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 99;
        bm  = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bm[c] = busy;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; op1 = '0; op2 = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 16'h0)   begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
        n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b0;
    endtask

    // Runs a table with inline comparisons of result, err, latency and busy profile.
    task automatic test_vectors(input string tag, input vec_t v[$]);
        int lat; logic [31:0] bm, exp_bm;
        foreach (v[i]) begin
            do_op(v[i].op, v[i].a, v[i].b, lat, bm);
            exp_bm = ((32'd1 << v[i].lat) - 32'd1) ^ 32'd1;
            n_checks++; if (result !== v[i].res) begin n_fail++; $display("FAIL %s[%0d] result: got %h expected %h", tag, i, result, v[i].res); end
            n_checks++; if (err !== v[i].err)    begin n_fail++; $display("FAIL %s[%0d] err: got %b expected %b", tag, i, err, v[i].err); end
            n_checks++; if (lat !== v[i].lat)    begin n_fail++; $display("FAIL %s[%0d] latency: got %0d expected %0d", tag, i, lat, v[i].lat); end
            n_checks++; if (bm !== exp_bm)       begin n_fail++; $display("FAIL %s[%0d] busy profile: got %h expected %h", tag, i, bm, exp_bm); end
        end
    endtask

    task automatic test_addsub();
        vec_t v[$];
        v.push_back('{ADDF, 16'h3F80, 16'h4000, 16'h4040, 1'b0, 4});  // 1+2=3
        v.push_back('{SUBF, 16'h3FC0, 16'h3FC0, 16'h0000, 1'b0, 4});  // x-x=0
        v.push_back('{ADDF, 16'h0000, 16'h4000, 16'h4000, 1'b0, 1});  // zero shortcut
        v.push_back('{SUBF, 16'h0000, 16'h4000, 16'hC000, 1'b0, 1});  // 0-2=-2 shortcut
        v.push_back('{SUBF, 16'h4000, 16'h3F80, 16'h3F80, 1'b0, 4});  // 2-1=1
        v.push_back('{ADDF, 16'h3F80, 16'hBF80, 16'h0000, 1'b0, 4});  // 1+(-1)=0
        v.push_back('{ADDF, 16'h3FC0, 16'h3FC0, 16'h4040, 1'b0, 4});  // 1.5+1.5=3
        test_vectors("addsub", v);
        // Result must hold while idle.
        repeat (3) @(negedge clk);
        n_checks++; if (result !== 16'h4040) begin n_fail++; $display("FAIL hold_result: got %h expected 4040", result); end
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL hold_done: got %b expected 0", done); end
    endtask

    task automatic test_mulf();
        vec_t v[$];
        v.push_back('{MULF, 16'h3FC0, 16'hC000, 16'hC040, 1'b0, 3});  // 1.5*-2=-3
        v.push_back('{MULF, 16'h7F00, 16'h7F00, 16'h7FFF, 1'b1, 3});  // overflow
        v.push_back('{MULF, 16'h0080, 16'h0080, 16'h0000, 1'b0, 3});  // underflow
        v.push_back('{MULF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1});  // zero shortcut
        test_vectors("mulf", v);
    endtask

    task automatic test_itof_ftoi();
        vec_t v[$];
        v.push_back('{ITOF, 16'h0000, 16'h06F8, 16'h44DF, 1'b0, 3});  // 1784
        v.push_back('{ITOF, 16'h0000, 16'h8000, 16'hC700, 1'b0, 3});  // -32768
        v.push_back('{ITOF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1});  // zero shortcut
        v.push_back('{FTOI, 16'h0000, 16'hC040, 16'hFFFD, 1'b0, 2});  // -3.0
        v.push_back('{FTOI, 16'h0000, 16'h4780, 16'h7FFF, 1'b1, 2});  // 65536 sat
        v.push_back('{FTOI, 16'h0000, 16'hC780, 16'h8000, 1'b1, 2});  // -65536 sat
        v.push_back('{FTOI, 16'h0000, 16'h3F00, 16'h0000, 1'b0, 2});  // 0.5 -> 0
        test_vectors("itof_ftoi", v);
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back('{3'd5, 16'h3F80, 16'h4000, 16'h0000, 1'b1, 1});
        v.push_back('{3'd7, 16'h4040, 16'h4040, 16'h0000, 1'b1, 1});
        test_vectors("illegal", v);
    endtask

    task automatic test_back_to_back();
        int pulses; int at[3]; logic [15:0] res[3]; logic load_next;
        pulses = 0; load_next = 1'b0;
        for (int k = 0; k < 3; k++) begin at[k] = 0; res[k] = '0; end
        @(negedge clk);
        start = 1'b1; op = ADDF; op1 = 16'h3F80; op2 = 16'h4000;
        @(posedge clk);
        #1 op = MULF; op1 = 16'h3FC0; op2 = 16'hC000;  // start stays high while busy
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (load_next) begin
                op = ITOF; op1 = 16'h0000; op2 = 16'h06F8;
                load_next = 1'b0;
            end
            if (done) begin
                if (pulses < 3) begin at[pulses] = c; res[pulses] = result; end
                pulses++;
                if (pulses == 1) load_next = 1'b1;
                if (pulses == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++; if (pulses !== 3)       begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
        n_checks++; if (at[0] !== 4)        begin n_fail++; $display("FAIL b2b_done0_cycle: got %0d expected 4", at[0]); end
        n_checks++; if (at[1] !== 7)        begin n_fail++; $display("FAIL b2b_done1_cycle: got %0d expected 7", at[1]); end
        n_checks++; if (at[2] !== 10)       begin n_fail++; $display("FAIL b2b_done2_cycle: got %0d expected 10", at[2]); end
        n_checks++; if (res[0] !== 16'h4040) begin n_fail++; $display("FAIL b2b_res0: got %h expected 4040", res[0]); end
        n_checks++; if (res[1] !== 16'hC040) begin n_fail++; $display("FAIL b2b_res1: got %h expected C040", res[1]); end
        n_checks++; if (res[2] !== 16'h44DF) begin n_fail++; $display("FAIL b2b_res2: got %h expected 44DF", res[2]); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_midop();
        int lat; int late_done; logic [31:0] bm;
        do_op(MULF, 16'h3FC0, 16'hC000, lat, bm);  // leaves a nonzero result
        n_checks++; if (result !== 16'hC040) begin n_fail++; $display("FAIL pre_reset_result: got %h expected C040", result); end
        @(negedge clk);
        start = 1'b1; op = ADDF; op1 = 16'h3F80; op2 = 16'h4000;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);           // cycle 1
        @(negedge clk);           // cycle 2
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        n_checks++; if (result !== 16'h0)   begin n_fail++; $display("FAIL midreset_result: got %h expected 0000", result); end
        n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL midreset_err: got %b expected 0", err); end
        @(negedge clk);
        reset = 1'b0;
        late_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) late_done++;
        end
        n_checks++; if (late_done !== 0)    begin n_fail++; $display("FAIL aborted_done: got %0d pulses expected 0", late_done); end
        do_op(ADDF, 16'h3FC0, 16'h3FC0, lat, bm);
        n_checks++; if (lat !== 4)           begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 4", lat); end
        n_checks++; if (result !== 16'h4040) begin n_fail++; $display("FAIL post_reset_result: got %h expected 4040", result); end
        n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL post_reset_err: got %b expected 0", err); end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mulf();
        test_itof_ftoi();
        test_illegal();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
